voxel_layer_seq: RTL

Upstream feeder for `LedCtrl`. It holds a double-buffered RGB565 voxel frame written by the host stream. It serves one layer's colours to `LedCtrl` through a registered read port, and sequences the cube layers. Each layer goes through: blank anodes, trigger a `LedCtrl` load/latch, then enable the layer's anode for a dwell period. Frames swap only at frame boundaries, so a displayed frame never tears.

---
 rtl/voxel_layer_seq_if.sv | 35 +++
 rtl/voxel_layer_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_layer_seq_if.sv
// ----------------------------------------------------------------------------
// voxel_layer_seq_if
//
// Purpose : Host pixel write stream into the voxel frame store. This is a
//           valid/ready stream of RGB565 pixels. The final pixel of each
//           frame is tagged with wrLast.
//
// Signals :
//   wrValid  host -> seq   pixel valid
//   wrReady  seq  -> host  pixel accepted when wrValid & wrReady
//   wrData   host -> seq   RGB565 pixel {R[15:11],G[10:5],B[4:0]}
//   wrLast   host -> seq   final pixel of a frame, qualified by the handshake
//
// Modports: master = host side, slave = voxel_layer_seq side.
// ----------------------------------------------------------------------------
interface voxel_layer_seq_if;
   logic        wrValid;
   logic        wrReady;
   logic [15:0] wrData;
   logic        wrLast;

   modport master (
      output wrValid,
      output wrData,
      output wrLast,
      input  wrReady
   );

   modport slave (
      input  wrValid,
      input  wrData,
      input  wrLast,
      output wrReady
   );
endinterface

// File: rtl/voxel_layer_seq.sv
// ----------------------------------------------------------------------------
// voxel_layer_seq
//
// Purpose : Upstream feeder for LedCtrl. It holds a double-buffered RGB565
//           voxel frame written by the host, and serves the current layer's
//           colours through a registered read port. It also sequences the
//           cube layers. For each layer it blanks the anodes, triggers a
//           LedCtrl load, then enables that layer's anode for a dwell
//           period. Banks swap only at frame boundaries, so a displayed
//           frame never tears.
//
// Ports   :
//   spiClk     single clock, shared with LedCtrl
//   nReset     asynchronous active-low reset
//   run        enable layer scanning
//   wr         host pixel stream (voxel_layer_seq_if.slave)
//   rdAddr     LED index within the current layer, driven by LedCtrl
//   ledColBuf  registered front-bank pixel at [curLayer*LPL + rdAddr]
//   cmdStart   one-cycle load request to LedCtrl
//   ctrlBusy   LedCtrl busy
//   cmdDone    LedCtrl completion pulse (latch already fired)
//   layerEn    one-hot anode enable, zero outside the dwell phase
//   curLayer   layer being loaded/shown
//   frameSync  one-cycle pulse when the banks swap
//   frameErr   one-cycle pulse when the write pointer wraps without wrLast
// ----------------------------------------------------------------------------
module voxel_layer_seq #(
   parameter  int NUM_SHIFT_CHANNEL = 4,
   parameter  int NUM_LAYERS        = 8,
   parameter  int BLANK_CYCLES      = 16,
   parameter  int DWELL_CYCLES      = 2000,
   localparam int LPL               = NUM_SHIFT_CHANNEL * 32,
   localparam int RA_W              = $clog2(LPL),
   localparam int LY_W              = $clog2(NUM_LAYERS)
) (
   input  logic                  spiClk,
   input  logic                  nReset,
   input  logic                  run,
   voxel_layer_seq_if.slave      wr,
   input  logic [RA_W-1:0]       rdAddr,
   output logic [15:0]           ledColBuf,
   output logic                  cmdStart,
   input  logic                  ctrlBusy,
   input  logic                  cmdDone,
   output logic [NUM_LAYERS-1:0] layerEn,
   output logic [LY_W-1:0]       curLayer,
   output logic                  frameSync,
   output logic                  frameErr
);

   localparam int FRAME_PIX = NUM_LAYERS * LPL;
   localparam int WP_W      = $clog2(FRAME_PIX);
   localparam int MA_W      = $clog2(2 * FRAME_PIX);
   localparam int CNT_MAX   = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_LOAD,
      S_SHOW
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [LY_W-1:0]   layer_nxt;
   logic              front_sel;
   logic              front_nxt;
   logic              swap_clr;
   logic              sync_nxt;

   logic              swap_pending;
   logic [WP_W-1:0]   wr_ptr;
   logic              wr_fire;
   logic              wr_at_end;
   logic [MA_W-1:0]   wr_idx;
   logic [MA_W-1:0]   rd_idx;

   logic [15:0]       mem [2*FRAME_PIX];

   // The back bank accepts no pixels while a finished frame waits for its
   // swap. This keeps a second wrLast from ever colliding with a swap.
   assign wr.wrReady = !swap_pending;
   assign wr_fire    = wr.wrValid & wr.wrReady;
   assign wr_at_end  = (wr_ptr == WP_W'(FRAME_PIX - 1));

   // Bank 0 occupies the lower half of the store and bank 1 the upper half.
   // Both banks are laid out layer-major.
   assign wr_idx = (front_sel ? '0 : MA_W'(FRAME_PIX)) + MA_W'(wr_ptr);
   assign rd_idx = (front_sel ? MA_W'(FRAME_PIX) : '0)
                 + MA_W'(curLayer) * MA_W'(LPL)
                 + MA_W'(rdAddr);

   // Frame store write port. The contents are intentionally not reset, so
   // that a short frame leaves the tail of the back bank as it was.
   always_ff @(posedge spiClk) begin
      if (wr_fire) begin
         mem[wr_idx] <= wr.wrData;
      end
   end

   // Registered read port. It is always live, because LedCtrl presents each
   // address one cycle before it samples the colour.
   always_ff @(posedge spiClk or negedge nReset) begin
      if (!nReset) begin
         ledColBuf <= '0;
      end else begin
         ledColBuf <= mem[rd_idx];
      end
   end

   // Write pointer and swap request. wrLast ends a frame at any length. A
   // full frame without wrLast wraps the pointer, flags an error, and
   // requests no swap.
   always_ff @(posedge spiClk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr       <= '0;
         swap_pending <= 1'b0;
         frameErr     <= 1'b0;
      end else begin
         frameErr <= 1'b0;
         if (swap_clr) begin
            swap_pending <= 1'b0;
         end
         if (wr_fire) begin
            if (wr.wrLast) begin
               wr_ptr       <= '0;
               swap_pending <= 1'b1;
            end else if (wr_at_end) begin
               wr_ptr   <= '0;
               frameErr <= 1'b1;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   // Layer sequencer state register. frameSync is registered so that it
   // lands in the first blanked cycle after the last layer's dwell.
   always_ff @(posedge spiClk or negedge nReset) begin
      if (!nReset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         curLayer  <= '0;
         front_sel <= 1'b0;
         frameSync <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         curLayer  <= layer_nxt;
         front_sel <= front_nxt;
         frameSync <= sync_nxt;
      end
   end

   // Next-state and output decode.
   // In BLANK the counter saturates at BLANK_CYCLES, so the anodes stay off
   // for the full blank time before cmdStart can fire. After that it waits
   // as long as LedCtrl is still busy.
   // In SHOW the counter runs for exactly DWELL_CYCLES cycles. The step off
   // the last layer is the only place where the banks may swap.
   // Dropping run is only honoured at the end of a layer.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      layer_nxt = curLayer;
      front_nxt = front_sel;
      swap_clr  = 1'b0;
      sync_nxt  = 1'b0;
      cmdStart  = 1'b0;
      layerEn   = '0;
      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_BLANK;
               cnt_nxt   = '0;
            end
         end
         S_BLANK: begin
            if (cnt != CNT_W'(BLANK_CYCLES)) begin
               cnt_nxt = cnt + 1'b1;
            end else if (!ctrlBusy) begin
               cmdStart  = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cmdDone) begin
               state_nxt = S_SHOW;
               cnt_nxt   = '0;
            end
         end
         S_SHOW: begin
            layerEn = NUM_LAYERS'(1) << curLayer;
            if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
               cnt_nxt   = '0;
               state_nxt = run ? S_BLANK : S_IDLE;
               if (curLayer == LY_W'(NUM_LAYERS - 1)) begin
                  layer_nxt = '0;
                  if (swap_pending) begin
                     front_nxt = ~front_sel;
                     swap_clr  = 1'b1;
                     sync_nxt  = 1'b1;
                  end
               end else begin
                  layer_nxt = curLayer + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
